// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM state encoding and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state;

endpackage

// File: rtl/apb_master_bridge.sv
// Command/response to APB requester bridge: one transfer at a time, every output
// registered, with a bounded wait for PREADY that turns a hung completer into an error.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,

  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  apb_master_state  state;
  logic [CNT_W-1:0] count;

  // NOTE: all state lives in one clocked block using <= only, so every output
  // is a flop and nothing depends on evaluation order between registers.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state       <= IDLE;
      count       <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is held low through reset, so it first rises one edge later.
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            PWRITE    <= cmd_write;
            PSEL      <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          count   <= CNT_ONE;
        end

        ACCESS: begin
          if (PREADY) begin
            state       <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            count       <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
          end else if (count == CNT_LAST) begin
            // Completer never answered: report it as a slave error flagged as timeout.
            state       <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            count       <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            count <= count + CNT_ONE;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench: directed and random transfers against a per-transaction
// model of the bridge's externally visible behaviour, plus reset scenarios.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pwrite, psel, penable, pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK       (pclk),
    .PRESET     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PADDR      (paddr),
    .PWDATA     (pwdata),
    .PWRITE     (pwrite),
    .PSEL       (psel),
    .PENABLE    (penable),
    .PRDATA     (prdata),
    .PREADY     (pready),
    .PSLVERR    (pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transfer. The completer answers on ACCESS cycle waits+1; the source
  // holds rsp_ready low for bp cycles of RESP. Expected results come from the
  // transaction-level rules: answer after TO cycles without PREADY is a timeout.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic [DW-1:0] rd, input logic err, input int bp);
    logic          exp_to, exp_err;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] hold_rdata;
    logic          hold_err, hold_to;
    int            exp_acc, acc, guard, t0;

    exp_to    = (waits + 1 > TO);
    exp_acc   = exp_to ? TO : waits + 1;
    exp_err   = exp_to ? 1'b1 : err;
    exp_rdata = (exp_to || wr) ? '0 : rd;

    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    check("accept_budget", 64'(guard < 20), 64'd1);
    t0 = cyc;

    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    check("setup_sel_en", {psel, penable}, 2'b10);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, wdata);
    check("setup_cmd_ready", cmd_ready, 1'b0);

    acc = 0;
    @(negedge pclk);
    while (psel && penable && acc < 20) begin
      acc++;
      check("access_paddr", paddr, addr);
      check("access_pwrite", pwrite, wr);
      check("access_pwdata", pwdata, wdata);
      pready  = (acc == waits + 1);
      prdata  = pready ? rd : $urandom;
      pslverr = pready ? err : 1'($urandom_range(0, 1));
      @(negedge pclk);
    end
    pready  = 1'b0;
    prdata  = $urandom;
    pslverr = 1'b1;

    check("access_cycles", acc, exp_acc);
    check("resp_valid", rsp_valid, 1'b1);
    check("resp_sel_en", {psel, penable}, 2'b00);
    check("resp_rdata", rsp_rdata, exp_rdata);
    check("resp_slverr", rsp_slverr, exp_err);
    check("resp_timeout", rsp_timeout, exp_to);
    check("resp_cmd_ready", cmd_ready, 1'b0);
    hold_rdata = rsp_rdata;
    hold_err   = rsp_slverr;
    hold_to    = rsp_timeout;

    repeat (bp) begin
      @(negedge pclk);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_rdata", rsp_rdata, hold_rdata);
      check("bp_slverr", rsp_slverr, hold_err);
      check("bp_timeout", rsp_timeout, hold_to);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    check("idle_valid", rsp_valid, 1'b0);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    check("idle_sel_en", {psel, penable}, 2'b00);
    check("idle_paddr_hold", paddr, addr);
    check("idle_pwdata_hold", pwdata, wdata);
    check("turnaround", cyc - t0, 3 + exp_acc + bp);
  endtask

  // Reset asserted between clock edges while the transfer waits in ACCESS.
  task automatic reset_in_access();
    int guard;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0040;
    cmd_wdata = 32'hA5A5_5A5A;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    pready    = 1'b0;
    @(negedge pclk);
    check("rst_pre_access", {psel, penable}, 2'b11);
    #2 preset = 1'b0;
    #1;
    check("rst_async_sel_en", {psel, penable}, 2'b00);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_paddr", paddr, '0);
    check("rst_pwdata", pwdata, '0);
    check("rst_pwrite", pwrite, 1'b0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    check("rst_release_ready", cmd_ready, 1'b1);
    repeat (5) begin
      @(negedge pclk);
      check("rst_no_rsp", rsp_valid, 1'b0);
      check("rst_no_sel", psel, 1'b0);
    end
  endtask

  initial begin
    preset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    repeat (3) @(negedge pclk);
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_sel_en", {psel, penable}, 2'b00);
    check("reset_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b000);
    check("reset_rdata", rsp_rdata, '0);
    check("reset_paddr", paddr, '0);
    preset = 1'b1;
    @(negedge pclk);
    check("first_edge_ready", cmd_ready, 1'b1);

    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);
    xfer(1'b0, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 1'b0, 0);
    xfer(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0, 32'h0, 1'b1, 0);
    xfer(1'b0, 32'h0000_0034, 32'h0, 10, 32'hFFFF_FFFF, 1'b0, 0);
    xfer(1'b0, 32'h0000_0038, 32'h0, 3, 32'h0BAD_CAFE, 1'b0, 0);
    xfer(1'b0, 32'h0000_003C, 32'h0, 1, 32'h5555_AAAA, 1'b1, 5);

    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 6),
           $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    reset_in_access();
    xfer(1'b0, 32'h0000_0044, 32'h0, 0, 32'h8765_4321, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum ACCESS cycles to wait for PREADY (range 1..65535).
REQ-004 SHALL have port PCLK  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port PRESET  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write); cmd_addr in ADDR_W; cmd_wdata in DATA_W.
REQ-007 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_W; rsp_slverr out 1; rsp_timeout out 1.
REQ-008 SHALL have APB requester ports: PADDR out ADDR_W; PWDATA out DATA_W; PWRITE out 1; PSEL out 1; PENABLE out 1; PRDATA in DATA_W; PREADY in 1; PSLVERR in 1.

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only, with no combinational path from APB inputs to outputs.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on a rising edge with cmd_valid&cmd_ready, latching cmd_write/cmd_addr/cmd_wdata, and the next state is SETUP.
REQ-011 SETUP SHALL last exactly one cycle: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA taken from the latched command; the next state is ACCESS.
REQ-012 ACCESS SHALL drive PSEL=1, PENABLE=1, with PADDR/PWRITE/PWDATA held identical to SETUP until the state is left.
REQ-013 In ACCESS, PREADY=1 at an edge SHALL complete the transfer: capture PRDATA into rsp_rdata for reads (write responses carry rsp_rdata=0), capture PSLVERR into rsp_slverr, set rsp_timeout=0, and go to RESP.
REQ-014 An ACCESS cycle counter SHALL start at 1 on the first ACCESS cycle.
REQ-015 If the counter equals TIMEOUT and PREADY=0, the bridge SHALL leave ACCESS to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-016 If PREADY=1 arrives on the TIMEOUT cycle itself, the bridge SHALL treat it as a normal completion with no timeout.
REQ-017 RESP SHALL drive PSEL=0, PENABLE=0, and rsp_valid=1, with rsp_* held stable until rsp_ready=1 at an edge; then the next state is IDLE.
REQ-018 IDLE SHALL drive PSEL=0, PENABLE=0, and rsp_valid=0; PADDR/PWDATA/PWRITE hold their last values.
REQ-019 The minimum turnaround SHALL be 4 cycles per transfer (IDLE, SETUP, ACCESS, RESP) when PREADY and rsp_ready are both 1.
REQ-020 Commands presented outside IDLE SHALL NOT be accepted or lost; cmd_valid stays asserted by the source until the handshake.
REQ-021 PSLVERR and PRDATA SHALL be ignored in every state other than ACCESS, and in ACCESS whenever PREADY=0.

Reset
REQ-022 While PRESET=0, the bridge SHALL hold: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, counter=0.
REQ-023 The bridge SHALL raise cmd_ready on the first rising edge after PRESET deasserts.
REQ-024 A reset mid-transfer SHALL abort the transfer immediately (PSEL/PENABLE low asynchronously) and SHALL produce no response.

Structure
REQ-025 The shared package apb_pkg SHALL hold the apb_master_state enum (logic [1:0]: IDLE, SETUP, ACCESS, RESP) and the constants APB_ADDR_W=32 and APB_DATA_W=32.
REQ-026 SHALL be a single module; the timeout counter is inline with width $clog2(TIMEOUT+1), and no sub-module is needed.

Verification
REQ-027 Write test: cmd write addr 0x10, data 0xDEADBEEF, PREADY tied 1 -> PSEL rises 1 cycle after accept, PENABLE 1 cycle later, rsp_valid in the 3rd cycle after accept, slverr=0.
REQ-028 Read test with wait states: addr 0x20, PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 with PREADY -> 4 ACCESS cycles with PADDR stable, rsp_rdata=0x12345678.
REQ-029 Error test: PSLVERR=1 with PREADY on a write -> rsp_slverr=1, rsp_timeout=0.
REQ-030 Timeout test: TIMEOUT=4, PREADY stuck 0 -> exactly 4 ACCESS cycles, then rsp_slverr=1, rsp_timeout=1, PSEL=0; a further case with PREADY on the 4th cycle -> normal completion.
REQ-031 Backpressure/reset test: rsp_ready held 0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout; separately, PRESET pulsed in ACCESS -> PSEL=0 immediately and no rsp_valid afterwards.
